// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer constants, fill sequencer state encoding and
// the rectangle validity helper.
package vga_pkg;

  localparam int H_PIXELS = 640;
  localparam int V_LINES  = 480;
  localparam int COLOR_W  = 12;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  // An inclusive rectangle is usable only if it is ordered and lies inside the visible frame.
  function automatic logic rect_valid(input logic [COL_W-1:0] x0,
                                      input logic [COL_W-1:0] x1,
                                      input logic [ROW_W-1:0] y0,
                                      input logic [ROW_W-1:0] y1);
    rect_valid = (x0 <= x1) && (y0 <= y1) &&
                 (x1 < COL_W'(H_PIXELS)) && (y1 < ROW_W'(V_LINES));
  endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// Raster cursor for the fill sequencer: loads the top-left corner and bounds,
// then steps left-to-right, top-to-bottom on each advance.
module fill_addr_gen
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             adv,
  input  logic [COL_W-1:0] x0,
  input  logic [COL_W-1:0] x1,
  input  logic [ROW_W-1:0] y0,
  input  logic [ROW_W-1:0] y1,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last_pixel
);

  logic [COL_W-1:0] x0_r;
  logic [COL_W-1:0] x1_r;
  logic [ROW_W-1:0] y1_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;

  assign row        = row_r;
  assign col        = col_r;
  assign last_pixel = (col_r == x1_r) && (row_r == y1_r);

  // Cursor and bounds; the cursor holds on the final pixel so it can never run past x1/y1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x0_r  <= '0;
      x1_r  <= '0;
      y1_r  <= '0;
      row_r <= '0;
      col_r <= '0;
    end else if (load) begin
      x0_r  <= x0;
      x1_r  <= x1;
      y1_r  <= y1;
      row_r <= y0;
      col_r <= x0;
    end else if (adv && !last_pixel) begin
      if (col_r < x1_r) begin
        col_r <= col_r + 10'd1;
      end else begin
        col_r <= x0_r;
        row_r <= row_r + 9'd1;
      end
    end
  end

endmodule

// File: rtl/vram_fill_ctrl.sv
// Rectangle-fill sequencer and VRAM write-port arbiter; the display read
// strobe (rdn low) always wins the port and simply stalls the fill.
module vram_fill_ctrl
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [COL_W-1:0]   x0,
  input  logic [COL_W-1:0]   x1,
  input  logic [ROW_W-1:0]   y0,
  input  logic [ROW_W-1:0]   y1,
  input  logic [COLOR_W-1:0] color,
  input  logic               rdn,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               we,
  output logic [ROW_W-1:0]   wr_row,
  output logic [COL_W-1:0]   wr_col,
  output logic [COLOR_W-1:0] wr_data
);

  fill_state_e        state;
  logic [COLOR_W-1:0] color_r;
  logic               valid_s;
  logic               load_s;
  logic               adv_s;
  logic               last_s;

  assign valid_s = rect_valid(x0, x1, y0, y1);
  assign load_s  = (state == IDLE) && start && valid_s;
  // Write enable follows rdn combinationally so the display never loses a read cycle.
  assign adv_s   = (state == FILL) && rdn;
  assign we      = adv_s;
  assign wr_data = color_r;

  fill_addr_gen u_addr (
    .clk        (clk),
    .rstn       (rstn),
    .load       (load_s),
    .adv        (adv_s),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .row        (wr_row),
    .col        (wr_col),
    .last_pixel (last_s)
  );

  // Sequencer FSM with registered status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      color_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= start && !valid_s;
          busy <= start && valid_s;
          if (start && valid_s) begin
            color_r <= color;
            state   <= FILL;
          end else begin
            state   <= IDLE;
          end
        end
        FILL: begin
          err <= 1'b0;
          if (rdn && last_s) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            done  <= 1'b0;
            state <= FILL;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vram_fill_ctrl.md
# vram_fill_ctrl

Rectangle-fill sequencer and VRAM write-port arbiter for the VGA display path. A host requests a solid-colour fill of an inclusive rectangle in the 640x480 frame buffer. The block walks the rectangle in raster order and issues one 12-bit pixel write per permitted cycle. It yields the VRAM to the display controller whenever the display is reading (rdn low), so scan-out is never disturbed. It sits between the host/draw logic and the VRAM write port, clocked by the same pixel clock as the VGA controller and the VRAM.

## Interface
- H_PIXELS, 640, visible columns
- V_LINES, 480, visible rows
- COLOR_W, 12, pixel width (4:4:4 RGB)
- clk  in  1  pixel clock (same clock as VGA controller and VRAM)
- rstn  in  1  asynchronous, active-low reset
- start  in  1  fill request; sampled only in IDLE
- x0, x1  in  10  inclusive left/right column
- y0, y1  in  9  inclusive top/bottom row
- color  in  COLOR_W  fill colour; latched on accepted start
- rdn  in  1  display read strobe from VGA controller; active-low (0 = display owns VRAM this cycle)
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse after the last pixel write
- err  out  1  one-cycle pulse on a rejected start
- we  out  1  VRAM write enable, active-high
- wr_row  out  9  write row address
- wr_col  out  10  write column address
- wr_data  out  COLOR_W  write data

## Operation
- States: IDLE, FILL, DONE.
- IDLE, start=1, rectangle invalid:
  - invalid means x0>x1, y0>y1, x1>=H_PIXELS or y1>=V_LINES;
  - err=1 for the next cycle; state stays IDLE; nothing is latched.
- IDLE, start=1, rectangle valid:
  - latch x0, x1, y0, color;
  - load cursor to col=x0, row=y0;
  - go to FILL.
- FILL: we = (state==FILL) & rdn. This is combinational, and the rdn->we path is intentional. wr_row, wr_col and wr_data come directly from the cursor and colour registers.
- At each edge in FILL with rdn=1 (write performed), the cursor advances:
  - col<x1: col+1;
  - col==x1 and row<y1: col=x0, row+1;
  - col==x1 and row==y1: go to DONE.
- At an edge in FILL with rdn=0: cursor holds and no write occurs. Stalls have no limit.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored: not queued, no err.
- Address arithmetic is unsigned at native widths. The cursor never exceeds x1/y1, so no wrap past 639/479 is possible.
- Reset (any time, including mid-fill): immediately IDLE. busy, done, err, we = 0. wr_row, wr_col, wr_data = 0. The fill is abandoned; pixels already written stay written.

## Timing
- start accepted at edge T: busy=1 from T+1, first write possible in cycle T+1.
- With rdn held 1, an N-pixel rectangle (N = (x1-x0+1)*(y1-y0+1)):
  - we is high for cycles T+1 .. T+N;
  - done and busy are high in cycle T+N+1;
  - busy=0 from T+N+2;
  - a new start is accepted at the edge ending cycle T+N+2 or later.
- Each cycle with rdn=0 during FILL extends completion by one cycle.
- err is asserted in cycle T+1 for a start rejected at edge T. busy stays 0.
- we is never 1 in a cycle where rdn=0.

## Structure
- Shared package vga_pkg holds:
  - constants H_PIXELS=640, V_LINES=480, COLOR_W=12, ROW_W=9, COL_W=10;
  - the fill state enum {IDLE, FILL, DONE}.
- One sub-module is natural: fill_addr_gen. It holds the raster cursor (load x0/y0, advance enable, x0/x1/y1 bounds) and outputs row, col and last_pixel. The FSM, validity check and rdn gating stay in vram_fill_ctrl.

## Test plan
- Rect (0,0)-(3,1), color=12'hF00, rdn=1 -> we high 8 consecutive cycles; (row,col) = (0,0),(0,1),(0,2),(0,3),(1,0),(1,1),(1,2),(1,3), wr_data=12'hF00 throughout; done one cycle later; busy high 9 cycles.
- Same rect, rdn alternating 0/1 starting with 0 -> we only in rdn=1 cycles, same 8-address sequence with no skips or repeats; done 17 cycles after start; we never high while rdn=0.
- start with x0=5, x1=4 -> err pulse next cycle, busy=0, we=0. Repeat with x1=640, then y1=480 -> err each time.
- Single pixel (639,479), color=12'h0AB -> exactly one write at row 479, col 639; done next cycle. start pulsed during FILL of a 100-pixel rect -> ignored, exactly 100 writes.
- rstn low for 1 cycle mid-way through a 640x480 fill -> we, busy, done = 0 immediately. New fill (10,10)-(11,10) then completes with writes (10,10),(10,11) only.
